// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encodings and bus widths.
package memory_arbiter_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_DATA_W = 32;

    // Unmapped address: no ROM, I/O or RAM select is active while the bus idles.
    localparam logic [ARB_ADDR_W-1:0] DEFAULT_IDLE_ADDRESS = 16'hFFFF;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester pick: a lone requester wins; ties go to port 0 under fixed
// priority, otherwise to the port that did not own the previous access.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    input  logic fixed_priority,
    output logic pick
);

    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = fixed_priority ? 1'b0 : ~last_owner;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates CPU (port 0) and a secondary master (port 1) onto the single
// memory_controller interface; each access runs IDLE -> ACCESS -> DONE.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter bit                    FIXED_PRIORITY = 1'b0,
    parameter logic [ARB_ADDR_W-1:0] IDLE_ADDRESS   = DEFAULT_IDLE_ADDRESS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ARB_ADDR_W-1:0] address0,
    input  logic [ARB_ADDR_W-1:0] address1,
    input  logic [ARB_DATA_W-1:0] wdata0,
    input  logic [ARB_DATA_W-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [ARB_DATA_W-1:0] rdata0,
    output logic [ARB_DATA_W-1:0] rdata1,
    output logic [ARB_ADDR_W-1:0] mem_address,
    output logic [ARB_DATA_W-1:0] mem_data_in,
    output logic                  mem_we,
    input  logic [ARB_DATA_W-1:0] mem_data_out
);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [ARB_DATA_W-1:0] rdata0_q, rdata0_d;
    logic [ARB_DATA_W-1:0] rdata1_q, rdata1_d;

    logic                  pick;
    logic                  sel_we;
    logic [ARB_ADDR_W-1:0] sel_address;
    logic [ARB_DATA_W-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req0           (req0),
        .req1           (req1),
        .last_owner     (last_owner_q),
        .fixed_priority (FIXED_PRIORITY),
        .pick           (pick)
    );

    assign sel_we      = owner_q ? we1      : we0;
    assign sel_address = owner_q ? address1 : address0;
    assign sel_wdata   = owner_q ? wdata1   : wdata0;

    // NOTE: the reset is sampled at the clock edge, so asserting it during
    // ACCESS discards that access: no ack, no rdata capture, back to IDLE.
    // Reset values for last_owner (1) make the first tie go to port 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based
            // on pre-edge values, independent of statement order.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        mem_address  = IDLE_ADDRESS;
        mem_data_in  = '0;
        mem_we       = 1'b0;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (req0 || req1) begin
                    owner_d = pick;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                gnt0         = ~owner_q;
                gnt1         = owner_q;
                mem_address  = sel_address;
                mem_data_in  = sel_wdata;
                // Gating with reset_n keeps a write from landing on the reset edge.
                mem_we       = sel_we & reset_n;
                last_owner_d = owner_q;
                if (!sel_we) begin
                    if (owner_q) rdata1_d = mem_data_out;
                    else         rdata0_d = mem_data_out;
                end
                state_d = ARB_DONE;
            end
            ARB_DONE: begin
                gnt0    = ~owner_q;
                gnt1    = owner_q;
                ack0    = ~owner_q;
                ack1    = owner_q;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a scoreboard of expected acks and
// read data plus directed checks of grants, memory bus and reset behaviour.
module tb_memory_arbiter;

    typedef struct {
        logic        port;
        logic        is_read;
        logic [31:0] rdata;
        int          cycle;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [15:0] address0, address1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [15:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [31:0] mem_data_out;

    logic        fp_req0, fp_req1;
    logic        fp_gnt0, fp_gnt1, fp_ack0, fp_ack1;
    logic [31:0] fp_rdata0, fp_rdata1;
    logic [15:0] fp_mem_address;
    logic [31:0] fp_mem_data_in;
    logic        fp_mem_we;
    logic [31:0] fp_mem_data_out;

    logic [31:0] ram [0:255];
    logic [31:0] model_rd [2];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    memory_arbiter u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .address0     (address0),
        .address1     (address1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .ack0         (ack0),
        .ack1         (ack1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out)
    );

    memory_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
        .clock        (clock),
        .reset_n      (reset_n),
        .req0         (fp_req0),
        .req1         (fp_req1),
        .we0          (1'b0),
        .we1          (1'b0),
        .address0     (16'h0001),
        .address1     (16'h0002),
        .wdata0       (32'h0),
        .wdata1       (32'h0),
        .gnt0         (fp_gnt0),
        .gnt1         (fp_gnt1),
        .ack0         (fp_ack0),
        .ack1         (fp_ack1),
        .rdata0       (fp_rdata0),
        .rdata1       (fp_rdata1),
        .mem_address  (fp_mem_address),
        .mem_data_in  (fp_mem_data_in),
        .mem_we       (fp_mem_we),
        .mem_data_out (fp_mem_data_out)
    );

    assign fp_mem_data_out = 32'h5A5A_5A5A;

    // Small RAM at 0x0000-0x00FF; everything else (including 0xFFFF) reads 0.
    assign mem_data_out = (mem_address[15:8] == 8'h00) ? ram[mem_address[7:0]] : 32'h0;
    always @(posedge clock) begin
        if (mem_we && mem_address[15:8] == 8'h00) ram[mem_address[7:0]] <= mem_data_in;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every ack must match the oldest expected completion.
    always @(negedge clock) begin
        exp_t e;
        check("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
        if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 64'({ack0, ack1}), 64'd0);
            end else begin
                e = sb.pop_front();
                check("ack_port", 64'({ack0, ack1}), e.port ? 64'b01 : 64'b10);
                check("ack_cycle", 64'(cyc), 64'(e.cycle));
                if (e.is_read) model_rd[e.port] = e.rdata;
                check("rdata0", 64'(rdata0), 64'(model_rd[0]));
                check("rdata1", 64'(rdata1), 64'(model_rd[1]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset_n  = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        address0 = 16'h0; address1 = 16'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        fp_req0 = 1'b0; fp_req1 = 1'b0;
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
        for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        ram[8'h41] <= 32'hDEAD_BEEF;
        ram[8'h42] <= 32'h1111_2222;
        ram[8'h10] <= 32'hA0A0_A0A0;
        ram[8'h20] <= 32'hB1B1_B1B1;

        repeat (2) tick();
        check("rst_gnt_ack", 64'({gnt0, gnt1, ack0, ack1}), 64'd0);
        check("rst_rdata", 64'({rdata0, rdata1}), 64'd0);
        check("rst_mem", 64'({mem_address, mem_data_in, mem_we}), 64'({16'hFFFF, 32'h0, 1'b0}));
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_bus", 64'({mem_address, mem_we, gnt0, gnt1, ack0, ack1}), 64'({16'hFFFF, 5'b0}));
        end

        // Single read on port 0.
        req0 = 1'b1; we0 = 1'b0; address0 = 16'h0041;
        sb.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF, cyc + 2});
        tick();
        check("rd_gnt", 64'({gnt0, gnt1}), 64'b10);
        check("rd_addr", 64'(mem_address), 64'h0041);
        check("rd_we", 64'(mem_we), 64'd0);
        tick();
        req0 = 1'b0;
        tick();
        check("rd_post_idle", 64'({gnt0, gnt1, ack0, ack1, mem_we}), 64'd0);

        // Port 1 write, then read back.
        req1 = 1'b1; we1 = 1'b1; address1 = 16'h0045; wdata1 = 32'h1234_5678;
        sb.push_back('{1'b1, 1'b0, 32'h0, cyc + 2});
        tick();
        check("wr_gnt", 64'({gnt0, gnt1}), 64'b01);
        check("wr_we", 64'(mem_we), 64'd1);
        check("wr_bus", 64'({mem_address, mem_data_in}), 64'({16'h0045, 32'h1234_5678}));
        tick();
        check("wr_we_done", 64'(mem_we), 64'd0);
        check("wr_ram", 64'(ram[8'h45]), 64'h1234_5678);
        req1 = 1'b0;
        tick();
        check("wr_we_idle", 64'(mem_we), 64'd0);
        req1 = 1'b1; we1 = 1'b0;
        sb.push_back('{1'b1, 1'b1, 32'h1234_5678, cyc + 2});
        tick();
        check("rb_we", 64'(mem_we), 64'd0);
        tick();
        req1 = 1'b0;
        tick();

        // Continuous tie in round-robin mode: grants 0,1,0,1, acks at +2,+5,+8,+11.
        address0 = 16'h0010; address1 = 16'h0020;
        c = cyc;
        req0 = 1'b1; req1 = 1'b1;
        sb.push_back('{1'b0, 1'b1, 32'hA0A0_A0A0, c + 2});
        sb.push_back('{1'b1, 1'b1, 32'hB1B1_B1B1, c + 5});
        sb.push_back('{1'b0, 1'b1, 32'hA0A0_A0A0, c + 8});
        sb.push_back('{1'b1, 1'b1, 32'hB1B1_B1B1, c + 11});
        for (int k = 0; k < 4; k++) begin
            tick();
            check("tie_gnt", 64'({gnt0, gnt1}), (k % 2 == 0) ? 64'b10 : 64'b01);
            tick();
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
        end

        // Reset asserted during the ACCESS cycle of a write to 0x0042.
        req0 = 1'b1; we0 = 1'b1; address0 = 16'h0042; wdata0 = 32'hCAFE_F00D;
        tick();
        check("rstw_gnt", 64'({gnt0, gnt1}), 64'b10);
        reset_n = 1'b0;
        #1;
        check("rstw_we", 64'(mem_we), 64'd0);
        check("rstw_ack", 64'({ack0, ack1}), 64'd0);
        req0 = 1'b0;
        tick();
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
        check("rstw_ram", 64'(ram[8'h42]), 64'h1111_2222);
        check("rstw_ctl", 64'({gnt0, gnt1, ack0, ack1}), 64'd0);
        check("rstw_rdata", 64'({rdata0, rdata1}), 64'd0);
        check("rstw_mem", 64'({mem_address, mem_data_in, mem_we}), 64'({16'hFFFF, 32'h0, 1'b0}));
        tick();
        reset_n = 1'b1;
        tick();
        check("rstw_after", 64'({gnt0, gnt1, ack0, ack1}), 64'd0);

        // Fixed priority instance: port 0 keeps winning until it drops its request.
        fp_req0 = 1'b1; fp_req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fp_gnt", 64'({fp_gnt0, fp_gnt1}), 64'b10);
            tick();
            check("fp_ack", 64'({fp_ack0, fp_ack1}), 64'b10);
            if (k == 2) fp_req0 = 1'b0;
            tick();
        end
        tick();
        check("fp_gnt1", 64'({fp_gnt0, fp_gnt1}), 64'b01);
        tick();
        check("fp_ack1", 64'({fp_ack0, fp_ack1}), 64'b01);
        check("fp_rdata", 64'({fp_rdata0, fp_rdata1}), 64'({32'h5A5A_5A5A, 32'h5A5A_5A5A}));
        fp_req1 = 1'b0;
        tick();

        repeat (3) tick();
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
